fifo_reader: RTL and testbench

- Read-side master for the team's synchronous FIFO. Drains words through the FIFO's rd/empty/dout port and re-presents them on a valid/ready stream.
- Hides the FIFO's one-cycle read latency with a small skid buffer, so it sustains one word per cycle under continuous downstream ready.
- Sits between the FIFO and any streaming consumer. The bench pairs it with the existing FIFO write-side stimulus.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_reader_skid_buf.sv | 51 +++++
 rtl/fifo_reader.sv | 87 ++++++++
 tb/tb_fifo_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side master: default word width, word type and reader FSM states.
package fifo_pkg;
  localparam int DATA_W_DEFAULT = 8;

  typedef logic [DATA_W_DEFAULT-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rdr_state_e;
endpackage

// File: rtl/fifo_reader_skid_buf.sv
// Circular skid buffer: push at tail, pop at head, head word always presented.
// Callers guarantee no push when full and no pop when empty.
module skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 2,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for the synchronous FIFO: issues rd, captures dout one cycle later into
// a skid buffer and re-presents words on a valid/ready stream at up to one word per cycle.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rd,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PEND_W = OCC_W + 1;

  rdr_state_e         state;
  logic               inflight;
  logic               pop;
  logic [OCC_W-1:0]   occ;
  logic [PEND_W-1:0]  pending;

  assign pop = m_valid && m_ready;

  // Slots committed after this cycle; crediting the pop lets rd issue every cycle while streaming.
  assign pending = PEND_W'(occ) + PEND_W'(inflight) - PEND_W'(pop);
  assign rd      = (state == RUN) && !empty && (pending < PEND_W'(BUF_DEPTH));
  assign m_valid = (occ != '0);

  skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= rd;
      if (pop) rd_count <= rd_count + 1'b1;
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) state <= DRAIN;
        end
        DRAIN: begin
          if (en) begin
            state <= RUN;
          end else if (occ == '0 && !inflight) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized bench for fifo_reader with a queue-based FIFO and stream reference model.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rd;
  logic        empty;
  word_t       fifo_dout;
  logic        m_valid;
  logic        m_ready;
  word_t       m_data;
  logic        busy;
  logic [15:0] rd_count;

  logic        rd_w;
  logic        m_valid_w;
  word_t       m_data_w;
  logic        busy_w;
  logic [3:0]  rd_count_w;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_W(8), .BUF_DEPTH(BUF_DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .rd(rd), .empty(empty), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .rd_count(rd_count)
  );

  fifo_reader #(.DATA_W(8), .BUF_DEPTH(BUF_DEPTH), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .en(en), .rd(rd_w), .empty(empty), .fifo_dout(fifo_dout),
    .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w), .busy(busy_w), .rd_count(rd_count_w)
  );

  int         checks = 0;
  int         failures = 0;
  word_t      fifo_q[$];
  word_t      exp_q[$];
  rdr_state_e ms;
  bit         infl_m;
  int         pops;
  int         rd_pulses;
  int         streak;
  int         max_streak;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_push(input word_t w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock: check outputs at negedge against the model, then advance model and FIFO.
  task automatic cycle();
    int         occ_m;
    bit         mv_exp;
    bit         pop;
    bit         rd_exp;
    bit         rd_taken;
    word_t      w;
    rdr_state_e ns;
    w = '0;
    @(negedge clk);
    occ_m  = exp_q.size() - int'(infl_m);
    mv_exp = (occ_m > 0);
    chk("m_valid", m_valid, mv_exp);
    if (mv_exp) chk("m_data", m_data, exp_q[0]);
    pop    = mv_exp && m_ready;
    rd_exp = (ms == RUN) && !empty && ((exp_q.size() - int'(pop)) < BUF_DEPTH);
    chk("rd", rd, rd_exp);
    chk("rd_w", rd_w, rd_exp);
    chk("rd_when_empty", rd && empty, 0);
    chk("busy", busy, ms != IDLE);
    chk("rd_count", rd_count, pops % 65536);
    chk("rd_count_wrap", rd_count_w, pops % 16);
    chk("occ_bound", dut.u_buf.occ <= BUF_DEPTH, 1);

    ns = ms;
    case (ms)
      IDLE:  if (en) ns = RUN;
      RUN:   if (!en) ns = DRAIN;
      DRAIN: if (en) ns = RUN; else if (occ_m == 0 && !infl_m) ns = IDLE;
      default: ns = IDLE;
    endcase
    if (pop) begin
      void'(exp_q.pop_front());
      pops++;
      streak++;
      if (streak > max_streak) max_streak = streak;
    end else begin
      streak = 0;
    end
    rd_taken = rd && !empty;
    if (rd_taken) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      rd_pulses++;
    end
    infl_m = rd_taken;
    ms     = ns;
    @(posedge clk);
    #1;
    if (rd_taken) fifo_dout = w;
    empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic flush_all();
    int guard;
    guard = 0;
    en = 1'b1;
    m_ready = 1'b1;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && guard < 100) begin
      cycle();
      guard++;
    end
    chk("flush_timeout", guard < 100, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int p0;
    int r0;
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; empty = 1'b1; fifo_dout = '0;
    ms = IDLE; infl_m = 1'b0; pops = 0; rd_pulses = 0; streak = 0; max_streak = 0;
    #2;
    chk("rst_rd", rd, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_count", rd_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(2);

    // Streaming: ten words back to back.
    for (int i = 1; i <= 10; i++) fifo_push(word_t'(i));
    en = 1'b1; m_ready = 1'b1; max_streak = 0;
    run(16);
    chk("stream_streak", max_streak, 10);
    chk("stream_count", rd_count, 10);
    chk("stream_busy", busy, 1);

    // Backpressure: stall six cycles, reads must stop at two outstanding.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_push(word_t'(8'h10 + i));
    r0 = rd_pulses;
    run(6);
    chk("bp_rd_pulses", rd_pulses - r0, 2);
    chk("bp_head", m_data, 8'h10);
    m_ready = 1'b1;
    p0 = pops;
    run(10);
    chk("bp_delivered", pops - p0, 6);

    // Drain on disable after three reads.
    for (int i = 0; i < 8; i++) fifo_push(word_t'(8'h20 + i));
    r0 = rd_pulses; p0 = pops;
    run(2);
    en = 1'b0;
    run(8);
    chk("drain_rd_pulses", rd_pulses - r0, 3);
    chk("drain_delivered", pops - p0, 3);
    chk("drain_fifo_left", fifo_q.size(), 5);
    chk("drain_busy", busy, 0);

    // Empty gap with random ready, then resume.
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    flush_all();
    run(4);
    chk("gap_m_valid", m_valid, 0);
    chk("gap_rd", rd, 0);
    for (int i = 0; i < 6; i++) fifo_push(word_t'(8'h30 + i));
    for (int i = 0; i < 20; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // Random traffic with occasional disable.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) fifo_push(word_t'($urandom));
      m_ready = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 9) != 0);
      cycle();
    end

    // Reset with a word in flight and the buffer occupied.
    flush_all();
    run(2);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_push(word_t'(8'h40 + i));
    run(2);
    chk("pre_rst_m_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_rd", rd, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_count", rd_count, 0);
    exp_q.delete(); infl_m = 1'b0; ms = IDLE; pops = 0;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    run(8);
    chk("post_rst_count", rd_count, 2);

    // Counter wrap on the narrow-counter instance.
    for (int i = 0; i < 16; i++) fifo_push(word_t'(8'h50 + i));
    run(25);
    chk("count18", rd_count, 18);
    chk("wrap_count", rd_count_w, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
